pipe_stage_buf: RTL
===================

// Module: pipe_stage_buf
// PURPOSE
//  Parametrised elastic pipeline-stage register; next generation of the fixed IF/ID latch.
//  - 2-entry skid buffer with valid/ready handshake on both sides, so stall back-pressure
//    is registered, not a combinational path.
//  - Synchronous flush and saturating bubble/stall counters for performance monitoring.
//  - Used between any two pipeline stages (IF/ID, ID/EX, ...) with the payload packed into data.
// PARAMETERS
//  DATA_W     64    payload width in bits (e.g. {pc4addr, instr})
//  FLUSH_VAL  0     DATA_W-bit value loaded into both entries on reset/flush
//  CNT_W      16    width of each performance counter
// PORTS
//  clk_i          in   1       clock, all logic on posedge
//  rst_i          in   1       synchronous reset, active-high
//  flush_i        in   1       synchronous flush, discards all buffered and incoming data
//  up_valid_i     in   1       upstream offers up_data_i
//  up_ready_o     out  1       stage can accept this cycle
//  up_data_i      in   DATA_W  upstream payload
//  dn_valid_o     out  1       dn_data_o is valid
//  dn_ready_i     in   1       downstream accepts this cycle
//  dn_data_o      out  DATA_W  payload to downstream, driven directly from the main register
//  bubble_cnt_o   out  CNT_W   cycles with dn_valid_o==0, saturating
//  stall_cnt_o    out  CNT_W   cycles with dn_valid_o==1 && dn_ready_i==0, saturating
// BEHAVIOUR
//  - Handshakes:
//    - push = up_valid_i & up_ready_o; pop = dn_valid_o & dn_ready_i.
//    - Transfer happens on the clock edge that closes a cycle in which the condition holds.
//  - State: EMPTY (no entry), ONE (main valid), TWO (main+skid valid).
//    - dn_valid_o = (state!=EMPTY); up_ready_o = (state!=TWO). Both decode state only;
//      no combinational path from dn_ready_i.
//  - Transitions (when neither rst_i nor flush_i is asserted):
//    - EMPTY: push -> ONE, main<=up_data_i; else stay EMPTY.
//    - ONE:   push&pop -> ONE, main<=up_data_i; push&!pop -> TWO, skid<=up_data_i;
//             !push&pop -> EMPTY; neither -> ONE, hold.
//    - TWO:   pop -> ONE, main<=skid; else hold (up_ready_o=0, so no push is possible).
//  - Ordering: strict FIFO, no loss, no duplication. Latency is 1 cycle from push to
//    dn_valid_o when the stage was EMPTY.
//  - dn_data_o changes only on a main load, reset or flush. In EMPTY it keeps its last value.
//  - Priority: rst_i > flush_i > normal operation.
//  - rst_i (next edge):
//    - state=EMPTY, main=skid=FLUSH_VAL, both counters=0.
//    - Outputs then read dn_valid_o=0, up_ready_o=1, dn_data_o=FLUSH_VAL.
//  - flush_i (next edge):
//    - state=EMPTY, main=skid=FLUSH_VAL.
//    - A push in the same cycle is dropped (upstream sees a handshake; the data is discarded).
//    - A pop in the same cycle counts as delivered.
//    - Counters are not cleared by flush.
//  - Mid-operation reset/flush in TWO: both entries are discarded; up_ready_o=1 next cycle.
//  - Counters:
//    - Evaluate every non-reset cycle, including flush cycles, using current-cycle dn_valid_o/dn_ready_i.
//    - Saturate at 2^CNT_W-1 (no wrap).
// TESTING
//  1. rst_i=1 for 2 cycles -> dn_valid_o=0, up_ready_o=1, dn_data_o=FLUSH_VAL, counters=0.
//  2. Streaming: dn_ready_i=1, push 0x11,0x22,0x33 on consecutive cycles ->
//     dn_data_o 0x11,0x22,0x33 one cycle later, up_ready_o stays 1.
//  3. Back-pressure: dn_ready_i=0, push 0xA then 0xB -> state TWO, up_ready_o=0,
//     stall_cnt_o increments each cycle. Raise dn_ready_i -> 0xA, then 0xB, then dn_valid_o=0.
//  4. Flush in TWO with up_valid_i=1 and data 0xC -> next cycle dn_valid_o=0,
//     dn_data_o=FLUSH_VAL; 0xC is never delivered.
//  5. CNT_W=4, idle 20 cycles after reset -> bubble_cnt_o=15 (saturated), no wrap to 0.
//  6. Random valid/ready for 10k cycles vs reference queue model -> in-order,
//     lossless, no duplicates, occupancy<=2.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: 2-entry skid buffer with registered back-pressure,
// synchronous flush and saturating bubble/stall performance counters.
module pipe_stage_buf #(
  parameter int unsigned              DATA_W    = 64,
  parameter logic [DATA_W-1:0]        FLUSH_VAL = '0,
  parameter int unsigned              CNT_W     = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic [CNT_W-1:0]  r_bubble;
  logic [CNT_W-1:0]  r_stall;
  logic              w_push;
  logic              w_pop;
  logic              w_main_from_up;
  logic              w_main_from_skid;
  logic              w_skid_from_up;

  // Handshake outputs decode state only, so dn_ready_i never reaches up_ready_o.
  assign dn_valid_o   = (r_state != EMPTY);
  assign up_ready_o   = (r_state != TWO);
  assign dn_data_o    = r_main;
  assign bubble_cnt_o = r_bubble;
  assign stall_cnt_o  = r_stall;

  assign w_push = up_valid_i & up_ready_o;
  assign w_pop  = dn_valid_o & dn_ready_i;

  always_comb begin
    w_state_nxt      = r_state;
    w_main_from_up   = 1'b0;
    w_main_from_skid = 1'b0;
    w_skid_from_up   = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_push) begin
          w_state_nxt    = ONE;
          w_main_from_up = 1'b1;
        end
      end
      ONE: begin
        if (w_push && w_pop) begin
          w_main_from_up = 1'b1;
        end else if (w_push) begin
          w_state_nxt    = TWO;
          w_skid_from_up = 1'b1;
        end else if (w_pop) begin
          w_state_nxt    = EMPTY;
        end
      end
      TWO: begin
        if (w_pop) begin
          w_state_nxt      = ONE;
          w_main_from_skid = 1'b1;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      r_state <= EMPTY;
      r_main  <= FLUSH_VAL;
      r_skid  <= FLUSH_VAL;
    end else begin
      r_state <= w_state_nxt;
      if (w_main_from_up) begin
        r_main <= up_data_i;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_skid_from_up) begin
        r_skid <= up_data_i;
      end
    end
  end

  // Counters keep running through flush; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bubble <= '0;
      r_stall  <= '0;
    end else begin
      if (!dn_valid_o && (r_bubble != '1)) begin
        r_bubble <= r_bubble + CNT_W'(1);
      end
      if (dn_valid_o && !dn_ready_i && (r_stall != '1)) begin
        r_stall <= r_stall + CNT_W'(1);
      end
    end
  end

endmodule
